stack_engine: RTL and testbench

- Parametrised successor to the fixed 32x256 stack datapath that currently drives the seven-segment display.
- Accepts one stack operation per handshake. Keeps top-of-stack (TOS) and next-on-stack (NOS) in registers and spills deeper entries to a synchronous-read memory, so there is never a same-cycle read/write hazard and no display flicker.
- Exports top item, emptiness, depth and sticky error flags for the display and instruction sequencer.

---
 rtl/stack_engine.sv | 174 +++++++++++++++++
 tb/tb_stack_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// Stack engine: TOS/NOS held in registers, deeper entries spilled to a
// synchronous-read memory; a one-cycle REFILL reloads NOS after a shrinking pop/add.
module stack_engine #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 256,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    output logic [WIDTH-1:0] top,
    output logic             not_empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf,
    output logic             carry
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] TWO_C  = CW'(2);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_REFILL = 1'b1} state_e;
    typedef enum logic [2:0] {
        OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_INC = 3'd3,
        OP_DUP = 3'd4, OP_ADD  = 3'd5, OP_SWAP = 3'd6, OP_CLR = 3'd7
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d, carry_q, carry_d;
    logic             ne_q, ne_d, ready_q, ready_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             mem_we_s, mem_re_s, accept_s;
    logic [AW-1:0]    spill_addr_s, refill_addr_s;
    logic [WIDTH:0]   sum_s, inc_s;
    op_e              op_s;

    // Memory holds entries 0..count-3; the spill slot sits just above, the refill slot is the highest one
    assign spill_addr_s  = cnt_q[AW-1:0] - AW'(2);
    assign refill_addr_s = cnt_q[AW-1:0] - AW'(3);
    assign accept_s      = op_valid && ready_q;
    assign op_s          = op_e'(op_code);
    assign sum_s         = {1'b0, tos_q} + {1'b0, nos_q};
    assign inc_s         = {1'b0, tos_q} + {{WIDTH{1'b0}}, 1'b1};

    // Next-state, datapath update and memory strobes
    always_comb begin
        state_d  = ST_RUN;
        tos_d    = tos_q;
        nos_d    = nos_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        carry_d  = carry_q;
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
        if (state_q == ST_REFILL) begin
            nos_d = rd_data_q;
        end else if (accept_s) begin
            case (op_s)
                OP_PUSH, OP_DUP: begin
                    if (cnt_q == FULL_C) begin
                        ovf_d = 1'b1;
                    end else begin
                        tos_d    = (op_s == OP_PUSH) ? op_imm : tos_q;
                        nos_d    = tos_q;
                        cnt_d    = cnt_q + ONE_C;
                        mem_we_s = (cnt_q >= TWO_C);
                    end
                end
                OP_POP: begin
                    if (cnt_q == ZERO_C) begin
                        udf_d = 1'b1;
                    end else begin
                        // Emptying the stack must leave top reading zero
                        tos_d    = (cnt_q == ONE_C) ? {WIDTH{1'b0}} : nos_q;
                        cnt_d    = cnt_q - ONE_C;
                        mem_re_s = (cnt_q > TWO_C);
                        state_d  = (cnt_q > TWO_C) ? ST_REFILL : ST_RUN;
                    end
                end
                OP_INC: begin
                    if (cnt_q == ZERO_C) begin
                        udf_d = 1'b1;
                    end else begin
                        tos_d   = inc_s[WIDTH-1:0];
                        carry_d = inc_s[WIDTH];
                    end
                end
                OP_ADD: begin
                    if (cnt_q < TWO_C) begin
                        udf_d = 1'b1;
                    end else begin
                        tos_d    = sum_s[WIDTH-1:0];
                        carry_d  = sum_s[WIDTH];
                        cnt_d    = cnt_q - ONE_C;
                        mem_re_s = (cnt_q > TWO_C);
                        state_d  = (cnt_q > TWO_C) ? ST_REFILL : ST_RUN;
                    end
                end
                OP_SWAP: begin
                    if (cnt_q < TWO_C) begin
                        udf_d = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                OP_CLR: begin
                    cnt_d   = ZERO_C;
                    tos_d   = {WIDTH{1'b0}};
                    nos_d   = {WIDTH{1'b0}};
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
                    carry_d = 1'b0;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end else begin
            state_d = ST_RUN;
        end
        ne_d    = (cnt_d != ZERO_C);
        ready_d = (state_d == ST_RUN);
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            tos_q   <= {WIDTH{1'b0}};
            nos_q   <= {WIDTH{1'b0}};
            cnt_q   <= ZERO_C;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            carry_q <= 1'b0;
            ne_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            carry_q <= carry_d;
            ne_q    <= ne_d;
            ready_q <= ready_d;
        end
    end

    // Spill/refill storage, intentionally left unreset
    always_ff @(posedge CLK) begin
        if (mem_we_s) mem_q[spill_addr_s] <= nos_q;
        if (mem_re_s) rd_data_q <= mem_q[refill_addr_s];
    end

    assign op_ready  = ready_q;
    assign top       = tos_q;
    assign not_empty = ne_q;
    assign count     = cnt_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign carry     = carry_q;
endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: two 8-bit instances (DEPTH 4 and 16)
// compared against an array-based stack model.
module tb_stack_engine;
    localparam int W = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         RST_N;
    logic         v_a, v_b;
    logic [2:0]   code_s;
    logic [W-1:0] imm_s;
    logic         rdy_a, ne_a, ovf_a, udf_a, car_a;
    logic         rdy_b, ne_b, ovf_b, udf_b, car_b;
    logic [W-1:0] top_a, top_b;
    logic [2:0]   cnt_a;
    logic [4:0]   cnt_b;

    stack_engine #(.WIDTH(W), .DEPTH(4)) u_a (
        .CLK(CLK), .RST_N(RST_N), .op_valid(v_a), .op_ready(rdy_a),
        .op_code(code_s), .op_imm(imm_s), .top(top_a), .not_empty(ne_a),
        .count(cnt_a), .ovf(ovf_a), .udf(udf_a), .carry(car_a));

    stack_engine #(.WIDTH(W), .DEPTH(16)) u_b (
        .CLK(CLK), .RST_N(RST_N), .op_valid(v_b), .op_ready(rdy_b),
        .op_code(code_s), .op_imm(imm_s), .top(top_b), .not_empty(ne_b),
        .count(cnt_b), .ovf(ovf_b), .udf(udf_b), .carry(car_b));

    int errors = 0;
    int checks = 0;

    // Reference model: plain array stack per instance
    logic [W-1:0] mstk [2][16];
    int           mcnt [2];
    int           mdepth [2];
    bit           movf [2], mudf [2], mcar [2];

    logic         obs_rdy, obs_ne, obs_ovf, obs_udf, obs_car;
    logic [W-1:0] obs_top;
    int           obs_cnt;

    function automatic logic [W-1:0] mtop(input int sel);
        return (mcnt[sel] > 0) ? mstk[sel][mcnt[sel]-1] : 8'd0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mcnt[s] = 0; movf[s] = 1'b0; mudf[s] = 1'b0; mcar[s] = 1'b0;
        end
    endtask

    task automatic grab(input int sel);
        if (sel == 0) begin
            obs_rdy = rdy_a; obs_top = top_a; obs_ne = ne_a; obs_cnt = int'(cnt_a);
            obs_ovf = ovf_a; obs_udf = udf_a; obs_car = car_a;
        end else begin
            obs_rdy = rdy_b; obs_top = top_b; obs_ne = ne_b; obs_cnt = int'(cnt_b);
            obs_ovf = ovf_b; obs_udf = udf_b; obs_car = car_b;
        end
    endtask

    // Offer one op (called at a negedge), hold until accepted, update model, sample at next negedge
    task automatic do_op(input int sel, input logic [2:0] code, input logic [W-1:0] imm,
                         output int waited, output bit exp_refill);
        int           c;
        logic [W-1:0] t, tmp;
        logic [W:0]   s;
        code_s = code; imm_s = imm; waited = 0; exp_refill = 1'b0;
        if (sel == 0) v_a = 1'b1; else v_b = 1'b1;
        grab(sel);
        while (!obs_rdy && waited < 8) begin
            @(negedge CLK); waited++; grab(sel);
        end
        if (!obs_rdy) begin
            errors++; checks++;
            $display("FAIL accept_timeout sel=%0d code=%0d got ready=0 exp ready=1", sel, code);
            v_a = 1'b0; v_b = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        v_a = 1'b0; v_b = 1'b0;
        c = mcnt[sel];
        t = mtop(sel);
        case (code)
            3'd1, 3'd4: begin
                if (c == mdepth[sel]) movf[sel] = 1'b1;
                else begin mstk[sel][c] = (code == 3'd1) ? imm : t; mcnt[sel]++; end
            end
            3'd2: if (c == 0) mudf[sel] = 1'b1; else mcnt[sel]--;
            3'd3: begin
                if (c == 0) mudf[sel] = 1'b1;
                else begin s = {1'b0, t} + 9'd1; mstk[sel][c-1] = s[W-1:0]; mcar[sel] = s[W]; end
            end
            3'd5: begin
                if (c < 2) mudf[sel] = 1'b1;
                else begin
                    s = {1'b0, t} + {1'b0, mstk[sel][c-2]};
                    mstk[sel][c-2] = s[W-1:0]; mcar[sel] = s[W]; mcnt[sel]--;
                end
            end
            3'd6: begin
                if (c < 2) mudf[sel] = 1'b1;
                else begin tmp = mstk[sel][c-1]; mstk[sel][c-1] = mstk[sel][c-2]; mstk[sel][c-2] = tmp; end
            end
            3'd7: begin mcnt[sel] = 0; movf[sel] = 1'b0; mudf[sel] = 1'b0; mcar[sel] = 1'b0; end
            default: ;
        endcase
        exp_refill = (code == 3'd2 || code == 3'd5) && (c > 2);
        @(negedge CLK);
        grab(sel);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            grab(s);
            checks++; if (obs_cnt !== 0) begin errors++; $display("FAIL reset_count sel=%0d got=%0d exp=0", s, obs_cnt); end
            checks++; if (obs_top !== 8'd0) begin errors++; $display("FAIL reset_top sel=%0d got=%0d exp=0", s, obs_top); end
            checks++; if ({obs_rdy, obs_ne, obs_ovf, obs_udf, obs_car} !== 5'b10000) begin
                errors++; $display("FAIL reset_flags sel=%0d got=%b exp=10000", s, {obs_rdy, obs_ne, obs_ovf, obs_udf, obs_car});
            end
        end
    endtask

    task automatic test_inc();
        int w, wsum; bit r;
        wsum = 0;
        do_op(1, 3'd1, 8'd5, w, r); wsum += w;
        do_op(1, 3'd3, 8'd0, w, r); wsum += w;
        do_op(1, 3'd3, 8'd0, w, r); wsum += w;
        checks++; if (obs_top !== 8'd7) begin errors++; $display("FAIL inc_top got=%0d exp=7", obs_top); end
        checks++; if (obs_cnt !== 1) begin errors++; $display("FAIL inc_count got=%0d exp=1", obs_cnt); end
        checks++; if (obs_car !== 1'b0) begin errors++; $display("FAIL inc_carry got=%0d exp=0", obs_car); end
        checks++; if (wsum !== 0) begin errors++; $display("FAIL inc_stall got=%0d exp=0", wsum); end
    endtask

    task automatic test_pop_refill();
        int w; bit r;
        do_op(1, 3'd7, 8'd0, w, r);
        for (int i = 1; i <= 4; i++) do_op(1, 3'd1, 8'(i), w, r);
        do_op(1, 3'd2, 8'd0, w, r);
        checks++; if (obs_top !== 8'd3 || obs_cnt !== 3) begin
            errors++; $display("FAIL pop1 got top=%0d cnt=%0d exp top=3 cnt=3", obs_top, obs_cnt);
        end
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL pop1_refill got ready=%0d exp=0", obs_rdy); end
        do_op(1, 3'd2, 8'd0, w, r);
        checks++; if (w !== 1) begin errors++; $display("FAIL pop2_held got wait=%0d exp=1", w); end
        checks++; if (obs_top !== 8'd2 || obs_cnt !== 2) begin
            errors++; $display("FAIL pop2 got top=%0d cnt=%0d exp top=2 cnt=2", obs_top, obs_cnt);
        end
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL pop2_refill got ready=%0d exp=0", obs_rdy); end
        do_op(1, 3'd2, 8'd0, w, r);
        checks++; if (obs_top !== 8'd1 || obs_rdy !== 1'b1) begin
            errors++; $display("FAIL pop3 got top=%0d ready=%0d exp top=1 ready=1", obs_top, obs_rdy);
        end
    endtask

    task automatic test_carry();
        int w; bit r;
        do_op(0, 3'd7, 8'd0, w, r);
        do_op(0, 3'd1, 8'd255, w, r);
        do_op(0, 3'd1, 8'd1, w, r);
        do_op(0, 3'd5, 8'd0, w, r);
        checks++; if (obs_top !== 8'd0 || obs_car !== 1'b1 || obs_cnt !== 1) begin
            errors++; $display("FAIL add_wrap got top=%0d carry=%0d cnt=%0d exp top=0 carry=1 cnt=1", obs_top, obs_car, obs_cnt);
        end
        do_op(0, 3'd3, 8'd0, w, r);
        checks++; if (obs_top !== 8'd1 || obs_car !== 1'b0) begin
            errors++; $display("FAIL inc_after_wrap got top=%0d carry=%0d exp top=1 carry=0", obs_top, obs_car);
        end
    endtask

    task automatic test_overflow();
        int w; bit r;
        do_op(0, 3'd7, 8'd0, w, r);
        for (int i = 0; i < 5; i++) do_op(0, 3'd1, 8'(8'd40 + 8'(i)), w, r);
        checks++; if (obs_cnt !== 4 || obs_ovf !== 1'b1 || obs_top !== 8'd43) begin
            errors++; $display("FAIL overflow got cnt=%0d ovf=%0d top=%0d exp cnt=4 ovf=1 top=43", obs_cnt, obs_ovf, obs_top);
        end
        for (int i = 0; i < 5; i++) do_op(0, 3'd2, 8'd0, w, r);
        checks++; if (obs_cnt !== 0 || obs_udf !== 1'b1 || obs_top !== 8'd0 || obs_ne !== 1'b0) begin
            errors++; $display("FAIL underflow got cnt=%0d udf=%0d top=%0d ne=%0d exp 0 1 0 0", obs_cnt, obs_udf, obs_top, obs_ne);
        end
        do_op(0, 3'd7, 8'd0, w, r);
        checks++; if (obs_ovf !== 1'b0 || obs_udf !== 1'b0) begin
            errors++; $display("FAIL clr_flags got ovf=%0d udf=%0d exp 0 0", obs_ovf, obs_udf);
        end
    endtask

    task automatic test_empty_err();
        int w, wsum; bit r;
        wsum = 0;
        do_op(1, 3'd7, 8'd0, w, r);
        do_op(1, 3'd6, 8'd0, w, r); wsum += w;
        checks++; if (obs_udf !== 1'b1 || obs_rdy !== 1'b1) begin
            errors++; $display("FAIL swap_empty got udf=%0d ready=%0d exp 1 1", obs_udf, obs_rdy);
        end
        do_op(1, 3'd5, 8'd0, w, r); wsum += w;
        checks++; if (obs_cnt !== 0 || obs_rdy !== 1'b1 || wsum !== 0) begin
            errors++; $display("FAIL add_empty got cnt=%0d ready=%0d wait=%0d exp 0 1 0", obs_cnt, obs_rdy, wsum);
        end
    endtask

    task automatic test_random();
        int w; bit r; int k; logic [2:0] code;
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = n % 2;
            k = $urandom_range(0, 15);
            if (k < 5) code = 3'd1;
            else if (k < 8 || k == 15) code = 3'd2;
            else if (k == 8) code = 3'd3;
            else if (k == 9) code = 3'd4;
            else if (k < 12) code = 3'd5;
            else if (k == 12) code = 3'd6;
            else if (k == 13) code = 3'd0;
            else code = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'd1;
            do_op(sel, code, 8'($urandom_range(0, 255)), w, r);
            checks++;
            if (obs_top !== mtop(sel) || obs_cnt !== mcnt[sel] || obs_ne !== (mcnt[sel] != 0) ||
                obs_ovf !== movf[sel] || obs_udf !== mudf[sel] || obs_car !== mcar[sel] || obs_rdy !== !r) begin
                errors++;
                $display("FAIL random n=%0d sel=%0d op=%0d got top=%0d cnt=%0d ne=%0d ovf=%0d udf=%0d c=%0d rdy=%0d exp top=%0d cnt=%0d ne=%0d ovf=%0d udf=%0d c=%0d rdy=%0d",
                         n, sel, code, obs_top, obs_cnt, obs_ne, obs_ovf, obs_udf, obs_car, obs_rdy,
                         mtop(sel), mcnt[sel], (mcnt[sel] != 0), movf[sel], mudf[sel], mcar[sel], !r);
            end
        end
    endtask

    task automatic test_reset_refill();
        int w; bit r;
        do_op(1, 3'd7, 8'd0, w, r);
        for (int i = 0; i < 5; i++) do_op(1, 3'd1, 8'(8'd10 + 8'(i)), w, r);
        do_op(1, 3'd2, 8'd0, w, r);
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL pre_reset_refill got ready=%0d exp=0", obs_rdy); end
        RST_N = 1'b0;
        #1;
        grab(1);
        checks++; if (obs_cnt !== 0 || obs_top !== 8'd0 || obs_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_refill got cnt=%0d top=%0d ready=%0d exp 0 0 1", obs_cnt, obs_top, obs_rdy);
        end
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        do_op(1, 3'd1, 8'h5A, w, r);
        checks++; if (obs_top !== 8'h5A || obs_cnt !== 1 || w !== 0) begin
            errors++; $display("FAIL post_reset_push got top=%0d cnt=%0d wait=%0d exp 90 1 0", obs_top, obs_cnt, w);
        end
    endtask

    initial begin
        RST_N = 1'b0; v_a = 1'b0; v_b = 1'b0; code_s = 3'd0; imm_s = 8'd0;
        mdepth[0] = 4; mdepth[1] = 16;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        test_reset();
        test_inc();
        test_pop_refill();
        test_carry();
        test_overflow();
        test_empty_err();
        test_random();
        test_reset_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
